// File: rtl/cfg_bus_arbiter.sv
// cfg_bus_arbiter: round-robin arbiter sharing one strobe-less switch register port among NUM_REQ requesters.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   i_req/i_req_rw    - per-requester request and direction (1=read, 0=write)
//   i_req_addr/wdata  - flattened per-requester address / write data
//   o_gnt/o_ack       - one-hot grant (ACCESS cycle) and completion pulse (DONE cycle)
//   o_rdata           - read data captured in ACCESS, held until the next read
//   o_busy            - high in ACCESS and DONE
//   o_addr/o_din/o_rw - switch register port, i_dout - switch combinational read data
module cfg_bus_arbiter #(
    parameter int                NUM_REQ   = 4,
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = 8'hFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ-1:0]         i_req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]  i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  i_req_wdata,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_busy,
    output logic [ADDR_W-1:0]          o_addr,
    output logic [DATA_W-1:0]          o_din,
    output logic                       o_rw,
    input  logic [DATA_W-1:0]          i_dout
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    state_t              r_state, w_next;
    logic [IW-1:0]       r_rr_last, w_rr_last, w_win, w_idx;
    logic [NUM_REQ-1:0]  r_gnt, r_ack, w_gnt, w_ack;
    logic [DATA_W-1:0]   r_rdata, w_rdata, r_din, w_din;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic                r_rw, w_rw, r_busy, w_busy;
    // Descending scan so the last hit is the first requester after r_rr_last.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = IW'((int'(r_rr_last) + k) % NUM_REQ);
            if (i_req[w_idx]) w_win = w_idx;
        end
    end
    always_comb begin
        w_next = r_state == S_IDLE   ? (|i_req ? S_ACCESS : S_IDLE) :
                 r_state == S_ACCESS ? S_DONE : S_IDLE;
    end
    // Idle bus is always a read of IDLE_ADDR: the port has no strobe, so rw=0 would write.
    always_comb begin
        w_gnt     = '0;
        w_ack     = '0;
        w_addr    = IDLE_ADDR;
        w_din     = '0;
        w_rw      = 1'b1;
        w_rdata   = r_rdata;
        w_rr_last = r_rr_last;
        w_busy    = w_next != S_IDLE;
        if (r_state == S_IDLE && |i_req) begin
            w_gnt     = NUM_REQ'(1) << w_win;
            w_addr    = ADDR_W'(i_req_addr >> (int'(w_win) * ADDR_W));
            w_din     = DATA_W'(i_req_wdata >> (int'(w_win) * DATA_W));
            w_rw      = i_req_rw[w_win];
            w_rr_last = w_win;
        end
        if (r_state == S_ACCESS) begin
            w_ack   = r_gnt;
            w_rdata = r_rw ? i_dout : r_rdata;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_rdata   <= '0;
            r_addr    <= IDLE_ADDR;
            r_din     <= '0;
            r_rw      <= 1'b1;
            r_rr_last <= IW'(NUM_REQ - 1);
        end else begin
            r_state   <= w_next;
            r_gnt     <= w_gnt;
            r_ack     <= w_ack;
            r_busy    <= w_busy;
            r_rdata   <= w_rdata;
            r_addr    <= w_addr;
            r_din     <= w_din;
            r_rw      <= w_rw;
            r_rr_last <= w_rr_last;
        end
    end
    assign o_gnt   = r_gnt;
    assign o_ack   = r_ack;
    assign o_busy  = r_busy;
    assign o_rdata = r_rdata;
    assign o_addr  = r_addr;
    assign o_din   = r_din;
    assign o_rw    = r_rw;
endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// tb_cfg_bus_arbiter: self-checking bench for cfg_bus_arbiter with a 16-word switch register model.
module tb_cfg_bus_arbiter;
    localparam int N = 4, AW = 8, DW = 32;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [N-1:0] req = '0, req_rw = '1;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0] gnt, ack;
    logic [DW-1:0] rdata, din, dout;
    logic [AW-1:0] addr;
    logic busy, rw;
    cfg_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .IDLE_ADDR(8'hFF)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_req_rw(req_rw), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_gnt(gnt), .o_ack(ack), .o_rdata(rdata), .o_busy(busy),
        .o_addr(addr), .o_din(din), .o_rw(rw), .i_dout(dout)
    );
    // Switch register file: 16 words preset to index*64, writes on any cycle with rw=0.
    logic [DW-1:0] mem [16];
    logic mem_ok = 1'b0;
    always @(posedge clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 16; i++) mem[i] <= DW'(i * 64);
            mem_ok <= 1'b1;
        end else if (!rw && addr < 8'd16) mem[addr[3:0]] <= din;
    end
    assign dout = (addr < 8'd16) ? mem[addr[3:0]] : '0;
    typedef struct {int idx; logic [DW-1:0] rd;} exp_t;
    typedef struct {int idx; logic rw; logic [AW-1:0] a; logic [DW-1:0] wd; logic [DW-1:0] rd;} vec_t;
    exp_t sb[$];
    vec_t vecs[9];
    int total = 0, bad = 0, cyc = 0;
    function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction
    // One clock: advance to the next falling edge, then check invariants and the scoreboard.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            chk("rw0_outside_access", (!rw && gnt == '0), 0);
            chk("gnt_ack_overlap", (|gnt && |ack), 0);
            chk("onehot", ($onehot0(gnt) && $onehot0(ack)), 1);
            chk("busy", busy, (|gnt || |ack));
            if (|ack) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack: got %0h want 0 (cycle %0d)", ack, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ack_idx", ack, 64'(1) << e.idx);
                    chk("rdata", rdata, e.rd);
                end
            end
        end
    endtask
    task automatic set_req(int i, logic r, logic [AW-1:0] a, logic [DW-1:0] d);
        req[i] = 1'b1;
        req_rw[i] = r;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        sb.delete();
        step();
        step();
        rst = 1'b0;
        step();
    endtask
    // Starts at an IDLE-cycle falling edge and returns at the next IDLE-cycle falling edge.
    task automatic run_txn(vec_t v);
        int n;
        set_req(v.idx, v.rw, v.a, v.wd);
        sb.push_back('{v.idx, v.rd});
        n = 0;
        do begin step(); n++; end while (!gnt[v.idx] && n < 10);
        chk("gnt_latency", n, 1);
        chk("bus_addr", addr, v.a);
        chk("bus_din", din, v.wd);
        chk("bus_rw", rw, v.rw);
        step();
        chk("ack_latency", ack, 64'(1) << v.idx);
        req[v.idx] = 1'b0;
        step();
    endtask
    // Wait for cnt acks, dropping each requester's req on its ack.
    task automatic wait_acks(int cnt);
        int got = 0;
        for (int n = 0; n < 40 && got < cnt; n++) begin
            step();
            if (|ack) begin
                got++;
                req = req & ~ack;
            end
        end
        chk("acks_done", got, cnt);
    endtask
    initial begin
        int n, lastc;
        vecs[0] = '{0, 1'b0, 8'h00, 32'h1,        32'h0};
        vecs[1] = '{1, 1'b1, 8'h00, 32'h0,        32'h1};
        vecs[2] = '{2, 1'b1, 8'h08, 32'h0,        32'd512};
        vecs[3] = '{3, 1'b0, 8'h05, 32'hDEADBEEF, 32'd512};
        vecs[4] = '{0, 1'b1, 8'h05, 32'h0,        32'hDEADBEEF};
        vecs[5] = '{1, 1'b0, 8'h40, 32'd123,      32'hDEADBEEF};
        vecs[6] = '{2, 1'b1, 8'h40, 32'h0,        32'h0};
        vecs[7] = '{3, 1'b1, 8'hFF, 32'h0,        32'h0};
        vecs[8] = '{1, 1'b1, 8'h02, 32'h0,        32'd128};
        step();
        #1;
        chk("rst_addr", addr, 8'hFF);
        chk("rst_rw", rw, 1);
        chk("rst_busy", busy, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_addr", addr, 8'hFF);
            chk("idle_rw", rw, 1);
            chk("idle_din", din, 0);
            chk("idle_gnt_ack", {gnt, ack}, 0);
            chk("idle_rdata", rdata, 0);
        end
        foreach (vecs[i]) run_txn(vecs[i]);
        // All four requesting continuously: strict 0,1,2,3 rotation, one ack per 3 cycles.
        do_reset();
        for (int k = 0; k < 8; k++) sb.push_back('{k % 4, DW'((10 + k % 4) * 64)});
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, AW'(10 + i), 32'h0);
        lastc = 0;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            do begin step(); n++; end while (!(|ack) && n < 10);
            if (k > 0) chk("rr_spacing", cyc - lastc, 3);
            lastc = cyc;
        end
        req = '0;
        step();
        // rr_last=1 then req=1001: requester 3 wins; its payload changes during ACCESS.
        do_reset();
        run_txn('{1, 1'b0, 8'h20, 32'h0, 32'h0});
        set_req(3, 1'b0, 8'h06, 32'hA5);
        set_req(0, 1'b1, 8'h06, 32'h0);
        sb.push_back('{3, 32'h0});
        sb.push_back('{0, 32'hA5});
        step();
        chk("rr_wrap_gnt", gnt, 4'b1000);
        set_req(3, 1'b1, 8'h07, 32'h5A);
        #1;
        chk("latched_addr", addr, 8'h06);
        chk("latched_din", din, 32'hA5);
        chk("latched_rw", rw, 0);
        wait_acks(2);
        step();
        // Reset during the ACCESS cycle of a write: bus idles at once, no ack, priority back to 0.
        set_req(0, 1'b0, 8'h04, 32'h77);
        n = 0;
        do begin step(); n++; end while (!gnt[0] && n < 10);
        chk("pre_rst_gnt", gnt, 4'b0001);
        #2;
        rst = 1'b1;
        #1;
        chk("async_addr", addr, 8'hFF);
        chk("async_rw", rw, 1);
        chk("async_din", din, 0);
        chk("async_gnt_ack", {gnt, ack}, 0);
        chk("async_busy", busy, 0);
        req = '0;
        sb.delete();
        step();
        step();
        rst = 1'b0;
        step();
        set_req(0, 1'b1, 8'h03, 32'h0);
        set_req(2, 1'b1, 8'h09, 32'h0);
        sb.push_back('{0, 32'd192});
        sb.push_back('{2, 32'd576});
        wait_acks(2);
        step();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
